add_seq: RTL
============

Name: add_seq

Overview:
- Parametrised, multi-cycle adder/subtractor; next generation of the 16-bit combinational adder.
- Processes CHUNK bits per clock using a registered ripple carry between chunks.
- Uses valid/ready handshakes on both input and output, and produces carry, signed-overflow and zero flags.
- Sits between the datapath register file and ALU result bus wherever area matters more than single-cycle latency.

Parameters:
- WIDTH, 16, operand/result width in bits.
- CHUNK, 4, bits added per cycle. CHUNK >= 1 and WIDTH % CHUNK == 0; elaboration fails otherwise.
- N (derived, not overridable), WIDTH/CHUNK, number of RUN cycles.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = add, 1 = subtract.
- cin  input  1  carry-in for add; borrow-in for subtract.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out  output  WIDTH  result.
- cout  output  1  final carry out of the MSB.
- ovf  output  1  two's-complement overflow.
- zero  output  1  out == 0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. While reset is high at an edge, state goes to IDLE, and out, cout, ovf, zero and out_valid clear to 0. in_valid is ignored during reset.
- Arithmetic:
  - Result = a + (sub ? ~b : b) + (cin ^ sub), modulo 2^WIDTH.
  - sub=1, cin=0 gives a-b; sub=1, cin=1 gives a-b-1.
  - cout = carry out of bit WIDTH-1. For subtract, cout=1 means no borrow.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero = (result == 0).
- State machine: IDLE, RUN, DONE.
  - IDLE: in_ready=1, out_valid=0. On an edge with in_valid=1:
    - latch a and the conditioned b;
    - carry register <= cin ^ sub;
    - chunk index <= 0;
    - go to RUN.
  - RUN: in_ready=0. Each edge adds chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) with the carry register, stores the partial sum and the new carry, then increments k. On the edge processing k = N-1:
    - out, cout, ovf and zero are loaded together;
    - go to DONE.
  - DONE: out_valid=1, in_ready=0. On an edge with out_ready=1, go to IDLE.
- Latency: out_valid rises exactly N cycles after the accept edge. CHUNK=WIDTH gives N=1.
- Throughput: one operation per N+2 cycles at best. There is no same-cycle re-accept on the DONE-to-IDLE transition.
- Output stability:
  - out and the flags change only on the final RUN edge, or on reset.
  - They hold their last result through DONE, IDLE and the next RUN.
  - Intermediate partial sums are never visible on out.
- Operand isolation: changes on a, b, sub or cin after acceptance have no effect. in_valid is ignored outside IDLE.
- Backpressure: out_ready low holds DONE indefinitely, with out_valid and outputs stable. out_ready while not in DONE is ignored.
- Reset mid-RUN or mid-DONE: the operation is aborted and no result is produced. in_ready=1 in the first cycle after reset deasserts.

Test Plan:
- WIDTH=16, CHUNK=4; a=0x1234, b=0x4321, sub=0, cin=0 -> out_valid rises 4 cycles after accept; out=0x5555, cout=0, ovf=0, zero=0.
- a=0xFFFF, b=0x0001, add -> out=0x0000, cout=1, zero=1, ovf=0. Then a=0x7FFF, b=0x0001 -> out=0x8000, ovf=1, cout=0.
- Subtract, sub=1, cin=0:
  - a=0x0005, b=0x0007 -> out=0xFFFE, cout=0, ovf=0.
  - a=0x0005, b=0x0005 -> out=0x0000, cout=1, zero=1.
  - a=0x8000, b=0x0001 -> out=0x7FFF, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, in_ready stays 0, and out/flags are stable. Toggling in_valid and a/b during RUN has no effect. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset asserted on the 2nd RUN cycle -> next cycle: out_valid=0, in_ready=1, out=0, all flags 0. A following a=0x0100, b=0x00FF add yields 0x01FF.
- CHUNK=16 and CHUNK=1 builds: latency 1 and 16 cycles respectively. The first three scenarios give identical results. Random-operand comparison against a reference model runs over 10k operations.

Source files
------------

// File: rtl/add_seq_if.sv
// Operand/result handshake bundle for the multi-cycle adder/subtractor.
// The master side presents operands and consumes results; the slave is the adder.
interface add_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, out, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, out, cout, ovf, zero
  );
endinterface

// File: rtl/add_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a registered ripple carry,
// valid/ready on both sides, and carry / signed-overflow / zero flags.
module add_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic      clk,
  input  logic      reset,
  add_seq_if.slave  bus
);

  localparam int CH = (CHUNK < 1) ? 1 : CHUNK;
  localparam int N  = WIDTH / CH;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  generate
    if (CHUNK < 1 || (WIDTH % CH) != 0) begin : g_bad_chunk
      $error("add_seq: CHUNK must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  // Operands are shifted right each RUN cycle so the live chunk is always the low bits;
  // the sum register fills from the top so it holds the full result after N steps.
  logic [CH-1:0]    a_chunk, b_chunk, s_chunk;
  logic             c_out;
  logic [WIDTH-1:0] sum_shift;
  logic             last_k;

  assign a_chunk          = a_q[CH-1:0];
  assign b_chunk          = b_q[CH-1:0];
  assign {c_out, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + (CH+1)'(carry_q);
  assign sum_shift        = (sum_q >> CH) | (WIDTH'(s_chunk) << (WIDTH - CH));
  assign last_k           = (k_q == KW'(N - 1));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    k_d     = k_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CH;
        b_d     = b_q >> CH;
        sum_d   = sum_shift;
        carry_d = c_out;
        k_d     = k_q + KW'(1);
        if (last_k) begin
          out_d   = sum_shift;
          cout_d  = c_out;
          // Carry into the MSB is recovered from the MSB's own sum bit.
          ovf_d   = a_chunk[CH-1] ^ b_chunk[CH-1] ^ s_chunk[CH-1] ^ c_out;
          zero_d  = (sum_shift == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // NOTE: staging registers are always loaded before they are read, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    sum_q   <= sum_d;
    carry_q <= carry_d;
    k_q     <= k_d;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule
